// File: rtl/stack_alu_ctrl.sv
// Stack ALU sequencer: pops one or two operands from the operand stack,
// executes one ALU opcode, pushes the result and reports zero/carry/err status.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | op_ready high, waiting for an opcode
// POP1  | first pop request (B, the old top of stack)
// POP2  | capture B; second pop request for binary ops
// EXEC  | capture A (binary), compute and register result and flags
// PUSH  | push result, pulse done, flags become visible
// ERR   | operand underflow, pulse err, opcode dropped
module stack_alu_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   output logic             op_ready,
   input  logic [CNT_W-1:0] stk_count,
   output logic             stk_pop_alu,
   input  logic [WIDTH-1:0] stk_rdata,
   output logic             stk_push,
   output logic [WIDTH-1:0] stk_wdata,
   output logic             done,
   output logic             err,
   output logic             zero,
   output logic             carry
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP1,
      S_POP2,
      S_EXEC,
      S_PUSH,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;

   logic [CNT_W-1:0] need_cnt;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             res_c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_ADD;
         b_q     <= '0;
         r_q     <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         b_q     <= b_d;
         r_q     <= r_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   // A is the live stack read data in EXEC; B was captured in POP2.
   always_comb begin
      sum   = {1'b0, stk_rdata} + {1'b0, b_q};
      res   = '0;
      res_c = 1'b0;
      case (op_q)
         OP_ADD: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
         end
         OP_SUB: begin
            res   = stk_rdata - b_q;
            res_c = (stk_rdata < b_q);
         end
         OP_AND:  res = stk_rdata & b_q;
         OP_OR:   res = stk_rdata | b_q;
         OP_XOR:  res = stk_rdata ^ b_q;
         OP_NOT:  res = ~b_q;
         OP_SHL:  res = stk_rdata << b_q[SH_W-1:0];
         OP_SHR:  res = stk_rdata >> b_q[SH_W-1:0];
         default: res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      b_d         = b_q;
      r_d         = r_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      op_ready    = 1'b0;
      stk_pop_alu = 1'b0;
      stk_push    = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      need_cnt    = (op_code == OP_NOT) ? CNT_W'(1) : CNT_W'(2);

      case (state_q)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               op_d    = op_code;
               state_d = (stk_count < need_cnt) ? S_ERR : S_POP1;
            end
         end
         S_POP1: begin
            stk_pop_alu = 1'b1;
            state_d     = S_POP2;
         end
         S_POP2: begin
            b_d         = stk_rdata;
            stk_pop_alu = (op_q != OP_NOT);
            state_d     = S_EXEC;
         end
         S_EXEC: begin
            r_d     = res;
            zero_d  = (res == '0);
            carry_d = res_c;
            state_d = S_PUSH;
         end
         S_PUSH: begin
            stk_push = 1'b1;
            done     = 1'b1;
            state_d  = S_IDLE;
         end
         S_ERR: begin
            err     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stk_wdata = r_q;
   assign zero      = zero_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// Bench for stack_alu_ctrl: a queue-based operand stack and an arithmetic
// reference model, driven by directed cases followed by random opcodes.
module tb_stack_alu_ctrl;

   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             op_valid = 1'b0;
   logic [2:0]       op_code = 3'b000;
   logic             op_ready;
   logic [CNT_W-1:0] stk_count = '0;
   logic             stk_pop_alu;
   logic [WIDTH-1:0] stk_rdata = '0;
   logic             stk_push;
   logic [WIDTH-1:0] stk_wdata;
   logic             done;
   logic             err;
   logic             zero;
   logic             carry;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] stk[$];
   logic [31:0] last_wd;
   logic        last_z, last_c;

   stack_alu_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .op_valid    (op_valid),
      .op_code     (op_code),
      .op_ready    (op_ready),
      .stk_count   (stk_count),
      .stk_pop_alu (stk_pop_alu),
      .stk_rdata   (stk_rdata),
      .stk_push    (stk_push),
      .stk_wdata   (stk_wdata),
      .done        (done),
      .err         (err),
      .zero        (zero),
      .carry       (carry)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint unsigned s;
      logic [31:0] r;
      logic c;
      c = 1'b0;
      case (op)
         3'd0: begin s = longint'(a) + longint'(b); r = s[31:0]; c = (s > 64'hFFFF_FFFF); end
         3'd1: begin r = a - b; c = (a < b); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~b;
         3'd6: r = a << b[4:0];
         default: r = a >> b[4:0];
      endcase
      return {c, r};
   endfunction

   // Called at a negedge: samples this cycle's requests, lets the clock edge
   // pass, then lets the stack react, and returns at the next negedge.
   task automatic step();
      logic p, q;
      logic [31:0] w;
      p = stk_pop_alu;
      q = stk_push;
      w = stk_wdata;
      @(posedge clock);
      #1;
      if (p && stk.size() > 0) stk_rdata = stk.pop_back();
      if (q) stk.push_back(w);
      stk_count = CNT_W'(stk.size());
      @(negedge clock);
   endtask

   task automatic load2(input logic [31:0] below, input logic [31:0] top);
      stk.delete();
      stk.push_back(below);
      stk.push_back(top);
      stk_count = CNT_W'(stk.size());
   endtask

   task automatic load1(input logic [31:0] top);
      stk.delete();
      stk.push_back(top);
      stk_count = CNT_W'(stk.size());
   endtask

   task automatic run_op(input logic [2:0] op);
      logic [31:0] a, b, exp_r;
      logic [32:0] rr;
      logic exp_c;
      int need, t, push_t, done_t, err_t, pop1_t, pop2_t, npops, ready_t;
      bit exp_err;
      need    = (op == 3'd5) ? 1 : 2;
      exp_err = (stk.size() < need);
      a = '0;
      b = '0;
      if (!exp_err) begin
         b = stk[stk.size()-1];
         if (need == 2) a = stk[stk.size()-2];
      end
      rr    = ref_alu(op, a, b);
      exp_r = rr[31:0];
      exp_c = rr[32];
      push_t = -1; done_t = -1; err_t = -1; pop1_t = -1; pop2_t = -1; npops = 0; ready_t = -1;

      chk("ready_t0", op_ready, 1);
      op_valid = 1'b1;
      op_code  = op;
      step();
      op_code  = 3'($urandom);
      op_valid = $urandom_range(0, 1) == 1;
      t = 1;
      while (!op_ready && t <= 8) begin
         chk("pop_push_excl", stk_pop_alu & stk_push, 0);
         if (stk_pop_alu) begin
            npops++;
            if (pop1_t < 0) pop1_t = t; else pop2_t = t;
         end
         if (stk_push) begin
            push_t  = t;
            last_wd = stk_wdata;
            last_z  = zero;
            last_c  = carry;
         end
         if (done) done_t = t;
         if (err) err_t = t;
         step();
         t++;
      end
      op_valid = 1'b0;
      if (op_ready) ready_t = t;
      chk("ready_cycle", ready_t, exp_err ? 2 : 5);
      if (exp_err) begin
         chk("err_cycle", err_t, 1);
         chk("err_no_pop", npops, 0);
         chk("err_no_push", push_t, -1);
         chk("err_no_done", done_t, -1);
      end else begin
         chk("pop1_cycle", pop1_t, 1);
         chk("pop_count", npops, need);
         if (need == 2) chk("pop2_cycle", pop2_t, 2);
         chk("push_cycle", push_t, 4);
         chk("done_cycle", done_t, 4);
         chk("no_err", err_t, -1);
         chk("wdata", last_wd, exp_r);
         chk("zero", last_z, exp_r == 0);
         chk("carry", last_c, exp_c);
         chk("zero_held", zero, exp_r == 0);
         chk("carry_held", carry, exp_c);
      end
   endtask

   initial begin
      logic [31:0] specials[6];
      int seen;
      specials = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h1F, 32'h7FFF_FFFF};

      #2;
      chk("rst_ready", op_ready, 1);
      chk("rst_pop", stk_pop_alu, 0);
      chk("rst_push", stk_push, 0);
      chk("rst_wdata", stk_wdata, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_zero", zero, 0);
      chk("rst_carry", carry, 0);
      @(negedge clock);
      step();
      reset = 1'b1;
      step();

      load2(32'h5, 32'h3);
      run_op(3'd1);
      chk("sub_5_3", last_wd, 32'h2);
      chk("sub_5_3_c", last_c, 0);
      chk("sub_5_3_z", last_z, 0);

      load2(32'hFFFF_FFFF, 32'h1);
      run_op(3'd0);
      chk("add_wrap", last_wd, 32'h0);
      chk("add_wrap_z", last_z, 1);
      chk("add_wrap_c", last_c, 1);

      load2(32'h3, 32'h5);
      run_op(3'd1);
      chk("sub_borrow", last_wd, 32'hFFFF_FFFE);
      chk("sub_borrow_c", last_c, 1);
      load1(32'hAAAA_0000);
      run_op(3'd5);
      chk("not", last_wd, 32'h5555_FFFF);
      chk("not_c", last_c, 0);

      load1(32'h1234);
      run_op(3'd0);
      stk.delete();
      stk_count = '0;
      run_op(3'd5);

      load2(32'h1, 32'h24);
      run_op(3'd6);
      chk("shl", last_wd, 32'h10);
      load2(32'h8000_0000, 32'h1F);
      run_op(3'd7);
      chk("shr", last_wd, 32'h1);

      // Reset in the middle of an ADD.
      load2(32'h10, 32'h20);
      op_valid = 1'b1;
      op_code  = 3'd0;
      step();
      op_valid = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", op_ready, 1);
      chk("mid_rst_pop", stk_pop_alu, 0);
      chk("mid_rst_push", stk_push, 0);
      chk("mid_rst_wdata", stk_wdata, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_zero", zero, 0);
      chk("mid_rst_carry", carry, 0);
      @(negedge clock);
      step();
      reset = 1'b1;
      seen = 0;
      repeat (6) begin
         if (stk_push || done) seen++;
         step();
      end
      chk("mid_rst_no_push", seen, 0);
      chk("mid_rst_ready_after", op_ready, 1);
      load2(32'hCCCC_0000, 32'hDDDD_0000);
      run_op(3'd4);
      chk("xor", last_wd, 32'h1111_0000);

      // Random opcodes, mostly back-to-back, with occasional underflow.
      stk.delete();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            while (stk.size() > 1) void'(stk.pop_back());
         end else begin
            while (stk.size() < 3 || (stk.size() < 10 && $urandom_range(0, 3) == 0)) begin
               if ($urandom_range(0, 2) == 0) stk.push_back(specials[$urandom_range(0, 5)]);
               else stk.push_back($urandom);
            end
         end
         stk_count = CNT_W'(stk.size());
         run_op(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 2) == 0) step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stack_alu_ctrl.md
# stack_alu_ctrl

Operation sequencer directly downstream of the 32-bit operand stack in the stack CPU. It accepts one ALU opcode at a time, pops one or two operands through the stack's ALU-pop port, computes the result and pushes it back onto the stack. It also reports zero, carry and error status to the control unit.

## Interface

Parameters:
- WIDTH, 32, datapath width (stack word width)
- CNT_W, 5, width of the stack occupancy count input

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  opcode offered by control unit
- op_code  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (unary), 110 SHL, 111 SHR
- op_ready  out  1  block idle, can accept opcode
- stk_count  in  CNT_W  current stack occupancy
- stk_pop_alu  out  1  pop request to stack ALU-pop port
- stk_rdata  in  WIDTH  stack top-of-stack data, valid the cycle after a pop
- stk_push  out  1  push request to stack
- stk_wdata  out  WIDTH  data to push
- done  out  1  one-cycle pulse, result pushed
- err  out  1  one-cycle pulse, operand underflow, opcode dropped
- zero  out  1  last result == 0, held until next done
- carry  out  1  last ADD carry-out / SUB borrow, 0 for other ops, held until next done

## Operation

- FSM states: IDLE, POP1, POP2, EXEC, PUSH, ERR.
- op_ready = 1 only in IDLE. An opcode is accepted when op_valid && op_ready; op_code is latched at that point.
- Operands needed: 1 for NOT, otherwise 2. On accept, if stk_count < needed, go to ERR; otherwise go to POP1.
- ERR: err=1 for one cycle, no stack traffic, then IDLE.
- POP1: stk_pop_alu=1, then POP2.
- POP2: capture B=stk_rdata. Binary ops drive stk_pop_alu=1; unary drives 0. Then EXEC.
- EXEC: binary captures A=stk_rdata. Result R computed and registered; zero/carry computed. Then PUSH.
- PUSH: stk_push=1, stk_wdata=R, done=1; zero/carry update in this cycle. Then IDLE.
- Arithmetic: operands are B=first pop (old top) and A=second pop.
  - ADD: R=A+B, carry=bit WIDTH of the WIDTH+1 sum.
  - SUB: R=A-B, carry=1 iff A<B unsigned.
  - AND/OR/XOR: bitwise.
  - NOT: R=~B.
  - SHL/SHR: A shifted logically by B[4:0].
  - All results truncated to WIDTH.
- Stack full is never reachable from this block: net occupancy change is -1 (binary) or 0 (unary), so no full check.
- stk_pop_alu and stk_push are never asserted in the same cycle.
- Opcodes presented while not IDLE are ignored; op_ready=0 signals the stall.

## Timing

- Reset values, all registered outputs: op_ready=1 (IDLE), stk_pop_alu=0, stk_push=0, stk_wdata=0, done=0, err=0, zero=0, carry=0.
- Accept at cycle T0:
  - T1 POP1
  - T2 POP2
  - T3 EXEC
  - T4 PUSH/done
  - T5 op_ready=1
- Throughput is one opcode per 5 cycles for both unary and binary ops.
- Underflow: accept at T0, err=1 at T1, op_ready=1 at T2.
- Stack read latency is one cycle: data for a pop in cycle N is sampled in cycle N+1.
- Reset asserted mid-operation:
  - Immediate return to IDLE; all outputs drop to reset values asynchronously.
  - Any partially popped operands are lost and no push occurs.
  - Control unit is responsible for re-initialising the stack.
- Back-to-back: op_valid held high at T5 is accepted at T5.

## Test plan

- Stack holds 0x0000_0005 (below), 0x0000_0003 (top), count=2; SUB -> pops at T1/T2, push 0x0000_0002 at T4, done=1, carry=0, zero=0.
- Stack holds 0xFFFF_FFFF, 0x0000_0001; ADD -> push 0x0000_0000, zero=1, carry=1.
- Stack holds 0x0000_0003 (below), 0x0000_0005 (top); SUB -> push 0xFFFF_FFFE, carry=1. Then NOT with count=1 on top 0xAAAA_0000 -> single pop, push 0x5555_FFFF, carry=0.
- count=1, ADD -> err pulse at T1, no stk_pop_alu/stk_push, op_ready back at T2. Repeat with count=0 and NOT -> same response.
- A=0x0000_0001, B=0x0000_0024 (shift by 4 via B[4:0]); SHL -> push 0x0000_0010. Then SHR with A=0x8000_0000, B=0x1F -> push 0x0000_0001.
- Reset low at T2 of an ADD -> all outputs 0 immediately, op_ready=1 after release, no push observed. A following XOR of 0xCCCC_0000 and 0xDDDD_0000 pushes 0x1111_0000.
